// File: rtl/iicmb_wb_sequencer_if.sv
// Wishbone master bus plus IICMB interrupt, as seen from the sequencer.
interface iicmb_wb_sequencer_if #(
   parameter int unsigned WB_ADDR_WIDTH = 2,
   parameter int unsigned WB_DATA_WIDTH = 8
) ();
   logic                     cyc_o;
   logic                     stb_o;
   logic                     we_o;
   logic [WB_ADDR_WIDTH-1:0] adr_o;
   logic [WB_DATA_WIDTH-1:0] dat_o;
   logic [WB_DATA_WIDTH-1:0] dat_i;
   logic                     ack_i;
   logic                     irq_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o,
      input  dat_i, ack_i, irq_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o,
      output dat_i, ack_i, irq_i
   );
endinterface

// File: rtl/iicmb_wb_sequencer.sv
// Runs complete I2C transactions on an IICMB controller over Wishbone:
// descriptor in, CSR/DPR/CMDR register sequence out, status decoded per command.
module iicmb_wb_sequencer #(
   parameter int unsigned WB_ADDR_WIDTH  = 2,
   parameter int unsigned WB_DATA_WIDTH  = 8,
   parameter int unsigned NUM_I2C_BUSSES = 1,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned LEN_WIDTH      = 8,
   localparam int unsigned BUS_W = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [BUS_W-1:0]         req_bus,
   input  logic [6:0]               req_addr,
   input  logic                     req_rw,
   input  logic [LEN_WIDTH-1:0]     req_len,
   input  logic                     wdata_valid,
   output logic                     wdata_ready,
   input  logic [WB_DATA_WIDTH-1:0] wdata,
   output logic                     rdata_valid,
   output logic [WB_DATA_WIDTH-1:0] rdata,
   output logic                     done,
   output logic [1:0]               status,
   iicmb_wb_sequencer_if.master     wb
);

   localparam logic [3:0] StInit    = 4'd0;
   localparam logic [3:0] StIdle    = 4'd1;
   localparam logic [3:0] StSetbus  = 4'd2;
   localparam logic [3:0] StStart   = 4'd3;
   localparam logic [3:0] StAddr    = 4'd4;
   localparam logic [3:0] StData    = 4'd5;
   localparam logic [3:0] StRddpr   = 4'd6;
   localparam logic [3:0] StStop    = 4'd7;
   localparam logic [3:0] StFin     = 4'd8;
   localparam logic [3:0] StWaitIrq = 4'd9;
   localparam logic [3:0] StRdcmdr  = 4'd10;
   localparam logic [3:0] StFlush   = 4'd11;

   localparam logic [2:0] CmdWrite   = 3'b001;
   localparam logic [2:0] CmdReadAck = 3'b010;
   localparam logic [2:0] CmdReadNak = 3'b011;
   localparam logic [2:0] CmdStart   = 3'b100;
   localparam logic [2:0] CmdStop    = 3'b101;
   localparam logic [2:0] CmdSetBus  = 3'b110;

   localparam logic [WB_ADDR_WIDTH-1:0] AdrCsr  = WB_ADDR_WIDTH'(0);
   localparam logic [WB_ADDR_WIDTH-1:0] AdrDpr  = WB_ADDR_WIDTH'(1);
   localparam logic [WB_ADDR_WIDTH-1:0] AdrCmdr = WB_ADDR_WIDTH'(2);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);
   localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

   // Write-data FIFO
   logic [WB_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          full, empty, push, pop;

   assign full        = (count_q == FullCnt);
   assign empty       = (count_q == '0);
   assign push        = wdata_valid && !full;
   assign wdata_ready = !full;

   // FIFO storage, deliberately unreset
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   // FIFO pointers and occupancy; pop is only raised when non-empty
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Sequencer state
   logic [3:0]               state_q, state_d, ret_q, ret_d;
   logic                     phase_q, phase_d;
   logic                     cyc_q, cyc_d, we_q, we_d;
   logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0] dat_q, dat_d, rdata_q, rdata_d;
   logic [BUS_W-1:0]         bus_q, bus_d;
   logic [6:0]               addr_q, addr_d;
   logic                     rw_q, rw_d, rvalid_q, rvalid_d;
   logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
   logic [1:0]               status_q, status_d;

   logic                     go, op_we, op_two, op_wait;
   logic [WB_ADDR_WIDTH-1:0] op_adr;
   logic [WB_DATA_WIDTH-1:0] op_dat;
   logic [3:0]               op_nxt, end_st;

   // Aborted or finished writes with bytes still owed must drain the FIFO first
   assign end_st = (!rw_q && cnt_q != '0) ? StFlush : StFin;

   // Per-state register operation selection plus the shared WB cycle engine
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      phase_d  = phase_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      bus_d    = bus_q;
      addr_d   = addr_q;
      rw_d     = rw_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      pop      = 1'b0;
      go       = 1'b0;
      op_we    = 1'b1;
      op_adr   = AdrCmdr;
      op_dat   = '0;
      op_two   = 1'b0;
      op_wait  = 1'b1;
      op_nxt   = state_q;

      case (state_q)
         StInit: begin
            go      = 1'b1;
            op_adr  = AdrCsr;
            op_dat  = WB_DATA_WIDTH'(8'hC0);
            op_wait = 1'b0;
            op_nxt  = StIdle;
         end
         StIdle: begin
            if (req_valid) begin
               bus_d    = req_bus;
               addr_d   = req_addr;
               rw_d     = req_rw;
               cnt_d    = req_len;
               status_d = 2'd0;
               state_d  = StSetbus;
            end
         end
         StSetbus: begin
            go     = 1'b1;
            op_two = 1'b1;
            op_adr = phase_q ? AdrCmdr : AdrDpr;
            op_dat = phase_q ? WB_DATA_WIDTH'(CmdSetBus) : WB_DATA_WIDTH'(bus_q);
            op_nxt = StStart;
         end
         StStart: begin
            go     = 1'b1;
            op_dat = WB_DATA_WIDTH'(CmdStart);
            op_nxt = StAddr;
         end
         StAddr: begin
            go     = 1'b1;
            op_two = 1'b1;
            op_adr = phase_q ? AdrCmdr : AdrDpr;
            op_dat = phase_q ? WB_DATA_WIDTH'(CmdWrite) : WB_DATA_WIDTH'({addr_q, rw_q});
            op_nxt = (cnt_q == '0) ? StStop : StData;
         end
         StData: begin
            if (rw_q) begin
               go     = 1'b1;
               op_dat = WB_DATA_WIDTH'((cnt_q == LenOne) ? CmdReadNak : CmdReadAck);
               op_nxt = StRddpr;
               if (cyc_q && wb.ack_i) cnt_d = cnt_q - 1'b1;
            end else begin
               // Stall with the bus idle until a byte is available
               go     = phase_q || cyc_q || !empty;
               op_two = 1'b1;
               op_adr = phase_q ? AdrCmdr : AdrDpr;
               op_dat = phase_q ? WB_DATA_WIDTH'(CmdWrite) : mem_q[rptr_q];
               op_nxt = (cnt_q == '0) ? StStop : StData;
               if (!phase_q && !cyc_q && !empty) begin
                  pop   = 1'b1;
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StRddpr: begin
            go      = 1'b1;
            op_we   = 1'b0;
            op_adr  = AdrDpr;
            op_wait = 1'b0;
            op_nxt  = (cnt_q == '0) ? StStop : StData;
            if (cyc_q && wb.ack_i) begin
               rdata_d  = wb.dat_i;
               rvalid_d = 1'b1;
            end
         end
         StStop: begin
            go     = 1'b1;
            op_dat = WB_DATA_WIDTH'(CmdStop);
            op_nxt = StFlush;
         end
         StWaitIrq: begin
            if (wb.irq_i) begin
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = AdrCmdr;
               dat_d   = '0;
               state_d = StRdcmdr;
            end
         end
         StRdcmdr: begin
            if (cyc_q && wb.ack_i) begin
               cyc_d = 1'b0;
               adr_d = '0;
               if (wb.dat_i[5]) begin
                  status_d = 2'd2;
                  state_d  = end_st;
               end else if (wb.dat_i[4]) begin
                  status_d = 2'd3;
                  state_d  = end_st;
               end else if (wb.dat_i[6] && (ret_q == StData || ret_q == StStop)) begin
                  // Only ADDR and write-DATA return to these states
                  status_d = 2'd1;
                  state_d  = StStop;
               end else if (wb.dat_i[7]) begin
                  state_d = (ret_q == StFlush) ? end_st : ret_q;
               end else begin
                  status_d = 2'd3;
                  state_d  = end_st;
               end
            end
         end
         StFlush: begin
            if (!empty) begin
               pop   = 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LenOne) state_d = StFin;
            end
         end
         StFin: state_d = StIdle;
         default: state_d = StInit;
      endcase

      if (go) begin
         if (!cyc_q) begin
            cyc_d = 1'b1;
            we_d  = op_we;
            adr_d = op_adr;
            dat_d = op_dat;
         end else if (wb.ack_i) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            dat_d = '0;
            if (op_two && !phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (op_wait) begin
                  state_d = StWaitIrq;
                  ret_d   = op_nxt;
               end else begin
                  state_d = op_nxt;
               end
            end
         end
      end
   end

   // State and registered outputs; reset drops the bus immediately
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StInit;
         ret_q    <= StIdle;
         phase_q  <= 1'b0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         bus_q    <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         cnt_q    <= '0;
         status_q <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         phase_q  <= phase_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         bus_q    <= bus_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign wb.cyc_o    = cyc_q;
   assign wb.stb_o    = cyc_q;
   assign wb.we_o     = we_q;
   assign wb.adr_o    = adr_q;
   assign wb.dat_o    = dat_q;
   assign req_ready   = (state_q == StIdle);
   assign done        = (state_q == StFin);
   assign status      = status_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// Directed bench for iicmb_wb_sequencer with a behavioural IICMB slave.
module tb_iicmb_wb_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_ready, req_rw;
   logic [2:0] req_bus;
   logic [6:0] req_addr;
   logic [7:0] req_len;
   logic       wdata_valid, wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid;
   logic [7:0] rdata;
   logic       done;
   logic [1:0] status;

   always #5 clk = ~clk;

   iicmb_wb_sequencer_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) wb_bus ();

   iicmb_wb_sequencer #(.NUM_I2C_BUSSES(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_bus     (req_bus),
      .req_addr    (req_addr),
      .req_rw      (req_rw),
      .req_len     (req_len),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .done        (done),
      .status      (status),
      .wb          (wb_bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] wlog[$];
   logic [7:0]  rd_src[$];
   logic [7:0]  rd_got[$];
   int          done_cnt = 0;
   logic [1:0]  done_status = 2'd0;
   logic        nak_addr = 1'b0;
   logic        al_start = 1'b0;
   logic        after_start;
   logic [7:0]  cmdr_stat;
   int          irq_cnt;

   logic [15:0] exp1 [10] = '{16'h0105, 16'h0206, 16'h0204, 16'h0144, 16'h0201,
                              16'h0144, 16'h0201, 16'h0178, 16'h0201, 16'h0205};
   logic [15:0] exp2 [9]  = '{16'h0100, 16'h0206, 16'h0204, 16'h0145, 16'h0201,
                              16'h0202, 16'h0202, 16'h0203, 16'h0205};
   logic [15:0] exp3 [6]  = '{16'h0103, 16'h0206, 16'h0204, 16'h0154, 16'h0201, 16'h0205};
   logic [15:0] exp4 [3]  = '{16'h0102, 16'h0206, 16'h0204};
   logic [7:0]  exp_rd [3] = '{8'hA1, 8'hB2, 8'hC3};

   // IICMB slave: one-cycle registered ack, irq three cycles after a CMDR write
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_bus.ack_i <= 1'b0;
         wb_bus.irq_i <= 1'b0;
         wb_bus.dat_i <= 8'h00;
         irq_cnt      <= 0;
         after_start  <= 1'b0;
         cmdr_stat    <= 8'h80;
      end else begin
         wb_bus.ack_i <= 1'b0;
         if (irq_cnt == 1) wb_bus.irq_i <= 1'b1;
         if (irq_cnt != 0) irq_cnt <= irq_cnt - 1;
         if (wb_bus.cyc_o && wb_bus.stb_o && !wb_bus.ack_i) begin
            wb_bus.ack_i <= 1'b1;
            if (wb_bus.we_o) begin
               wlog.push_back({6'd0, wb_bus.adr_o, wb_bus.dat_o});
               if (wb_bus.adr_o == 2'd2) begin
                  irq_cnt     <= 3;
                  after_start <= (wb_bus.dat_o == 8'h04);
                  if (wb_bus.dat_o == 8'h04 && al_start)
                     cmdr_stat <= 8'hA0;
                  else if (wb_bus.dat_o == 8'h01 && after_start && nak_addr)
                     cmdr_stat <= 8'hC0;
                  else
                     cmdr_stat <= 8'h80;
               end
            end else if (wb_bus.adr_o == 2'd2) begin
               wb_bus.dat_i <= cmdr_stat;
               wb_bus.irq_i <= 1'b0;
            end else if (rd_src.size() != 0) begin
               wb_bus.dat_i <= rd_src.pop_front();
            end else begin
               wb_bus.dat_i <= 8'h00;
            end
         end
      end
   end

   // Output monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (done) begin
         done_cnt    = done_cnt + 1;
         done_status = status;
      end
      if (rdata_valid) rd_got.push_back(rdata);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input int idx, input logic [15:0] exp);
      check(tag, (idx < wlog.size()) ? {16'h0, wlog[idx]} : 32'hDEAD, {16'h0, exp});
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      wdata_valid = 1'b1;
      wdata       = b;
      for (int k = 0; k < 500 && !wdata_ready; k++) @(negedge clk);
      @(negedge clk);
      wdata_valid = 1'b0;
   endtask

   task automatic send_req(input logic [2:0] b, input logic [6:0] a, input logic rw,
                           input logic [7:0] len);
      @(negedge clk);
      req_bus   = b;
      req_addr  = a;
      req_rw    = rw;
      req_len   = len;
      req_valid = 1'b1;
      for (int k = 0; k < 500 && !req_ready; k++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_drop", {31'd0, req_ready}, 32'd0);
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = done_cnt;
      for (int k = 0; k < budget && done_cnt == start; k++) @(negedge clk);
      check("done_seen", done_cnt - start, 1);
   endtask

   task automatic wait_log(input int n, input int budget);
      for (int k = 0; k < budget && wlog.size() < n; k++) @(negedge clk);
      check("log_reached", {31'd0, wlog.size() >= n}, 32'd1);
   endtask

   initial begin
      int busy;
      int snap;
      rst = 1'b1;
      req_valid = 1'b0; req_bus = '0; req_addr = '0; req_rw = 1'b0; req_len = '0;
      wdata_valid = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_cyc",     {31'd0, wb_bus.cyc_o}, 32'd0);
      check("rst_req_rdy", {31'd0, req_ready},    32'd0);
      check("rst_wd_rdy",  {31'd0, wdata_ready},  32'd1);
      check("rst_done",    {31'd0, done},         32'd0);
      check("rst_rvalid",  {31'd0, rdata_valid},  32'd0);
      check("rst_status",  {30'd0, status},       32'd0);
      rst = 1'b0;
      wait_log(1, 100);
      check_log("init_csr", 0, 16'h00C0);
      for (int k = 0; k < 100 && !req_ready; k++) @(negedge clk);

      // Write, bus 5, addr 0x22, two bytes
      wlog.delete();
      push_byte(8'h44);
      push_byte(8'h78);
      send_req(3'd5, 7'h22, 1'b0, 8'd2);
      wait_done(2000);
      check("wr_status", {30'd0, done_status}, 32'd0);
      check("wr_len", wlog.size(), 10);
      for (int i = 0; i < 10; i++) check_log("wr_seq", i, exp1[i]);

      // Read, three bytes
      wlog.delete();
      rd_got.delete();
      rd_src = '{8'hA1, 8'hB2, 8'hC3};
      send_req(3'd0, 7'h22, 1'b1, 8'd3);
      wait_done(2000);
      check("rd_status", {30'd0, done_status}, 32'd0);
      check("rd_len", wlog.size(), 9);
      for (int i = 0; i < 9; i++) check_log("rd_seq", i, exp2[i]);
      check("rd_count", rd_got.size(), 3);
      for (int i = 0; i < 3; i++)
         check("rd_byte", (i < rd_got.size()) ? {24'd0, rd_got[i]} : 32'hDEAD, {24'd0, exp_rd[i]});

      // Address NAK with the FIFO preloaded
      wlog.delete();
      nak_addr = 1'b1;
      for (int i = 0; i < 4; i++) push_byte(8'hE0 + 8'(i));
      send_req(3'd3, 7'h2A, 1'b0, 8'd4);
      wait_done(2000);
      nak_addr = 1'b0;
      check("nak_status", {30'd0, done_status}, 32'd1);
      check("nak_len", wlog.size(), 6);
      for (int i = 0; i < 6; i++) check_log("nak_seq", i, exp3[i]);

      // Arbitration lost after START
      wlog.delete();
      al_start = 1'b1;
      send_req(3'd2, 7'h10, 1'b1, 8'd1);
      wait_done(2000);
      al_start = 1'b0;
      check("al_status", {30'd0, done_status}, 32'd2);
      check("al_len", wlog.size(), 3);
      for (int i = 0; i < 3; i++) check_log("al_seq", i, exp4[i]);

      // FIFO fill (also proves the NAK flush left it empty), then a stalled 17-byte write
      wlog.delete();
      for (int i = 0; i < 15; i++) push_byte(8'(i));
      check("fifo_15_ready", {31'd0, wdata_ready}, 32'd1);
      push_byte(8'h0F);
      check("fifo_16_full", {31'd0, wdata_ready}, 32'd0);
      send_req(3'd1, 7'h50, 1'b0, 8'd17);
      wait_log(37, 3000);
      repeat (30) @(negedge clk);
      snap = wlog.size();
      busy = 0;
      repeat (50) begin
         @(negedge clk);
         if (wb_bus.cyc_o) busy++;
      end
      check("stall_no_wb", busy, 0);
      check("stall_log", wlog.size(), snap);
      push_byte(8'h99);
      wait_done(2000);
      check("long_status", {30'd0, done_status}, 32'd0);
      check("long_len", wlog.size(), 40);
      check_log("long_addr", 3, 16'h01A0);
      check_log("long_b0", 5, 16'h0100);
      check_log("long_b15", 35, 16'h010F);
      check_log("long_b16", 37, 16'h0199);
      check_log("long_stop", 39, 16'h0205);

      // Reset during a DATA-phase write cycle
      wlog.delete();
      push_byte(8'h11);
      push_byte(8'h22);
      send_req(3'd0, 7'h33, 1'b0, 8'd3);
      for (int k = 0; k < 2000 && !(wlog.size() >= 5 && wb_bus.cyc_o && wb_bus.we_o); k++)
         @(negedge clk);
      check("data_cyc_seen", {31'd0, wb_bus.cyc_o}, 32'd1);
      snap = done_cnt;
      rst = 1'b1;
      #1;
      check("mid_rst_cyc", {31'd0, wb_bus.cyc_o}, 32'd0);
      check("mid_rst_stb", {31'd0, wb_bus.stb_o}, 32'd0);
      check("mid_rst_we",  {31'd0, wb_bus.we_o},  32'd0);
      check("mid_rst_adr", {30'd0, wb_bus.adr_o}, 32'd0);
      check("mid_rst_dat", {24'd0, wb_bus.dat_o}, 32'd0);
      check("mid_rst_wd_rdy", {31'd0, wdata_ready}, 32'd1);
      repeat (3) @(negedge clk);
      wlog.delete();
      rst = 1'b0;
      wait_log(1, 100);
      check_log("reinit_csr", 0, 16'h00C0);
      repeat (20) @(negedge clk);
      check("no_done_on_rst", done_cnt, snap);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
